// File: rtl/mmio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mmio_bus_arbiter
//
// Shares one FPro MMIO bus among N_M masters (e.g. CPU and a UART debug
// bridge). Arbitration is round-robin with an optional per-master lock that
// keeps ownership across back-to-back transfers for atomic read-modify-write
// sequences. Each grant produces exactly one registered single-cycle FPro
// transaction; the read data is registered back to the masters.
//
// Transfer timeline (req first sampled at edge k):
//   cycle k+1 : BUS  - mmio_cs and one strobe high, m_gnt[g] high
//   cycle k+2 : ACK  - m_ack[g] pulse, m_gnt[g] high, m_rd_data valid
// so at most one transfer every three cycles.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   m_req         per-master request, held with its fields until m_ack
//   m_wr          per-master direction (1 = write, 0 = read)
//   m_lock        per-master lock request, sampled during the ACK cycle
//   m_addr        packed addresses, master i at [i*AW +: AW]
//   m_wr_data     packed write data, master i at [i*DW +: DW]
//   m_gnt         one-hot grant, high in the BUS and ACK cycles
//   m_ack         one-hot single-cycle completion pulse
//   m_rd_data     registered read data, valid with m_ack of a read
//   mmio_cs       FPro chip select
//   mmio_wr       FPro write strobe
//   mmio_rd       FPro read strobe
//   mmio_addr     FPro address (holds last value between transfers)
//   mmio_wr_data  FPro write data (holds last value between transfers)
//   mmio_rd_data  FPro read data, combinational from the addressed slot
// ---------------------------------------------------------------------------
module mmio_bus_arbiter #(
    parameter int N_M = 2,
    parameter int AW  = 21,
    parameter int DW  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_M-1:0]    m_req,
    input  logic [N_M-1:0]    m_wr,
    input  logic [N_M-1:0]    m_lock,
    input  logic [N_M*AW-1:0] m_addr,
    input  logic [N_M*DW-1:0] m_wr_data,
    output logic [N_M-1:0]    m_gnt,
    output logic [N_M-1:0]    m_ack,
    output logic [DW-1:0]     m_rd_data,
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [AW-1:0]     mmio_addr,
    output logic [DW-1:0]     mmio_wr_data,
    input  logic [DW-1:0]     mmio_rd_data
);

    localparam int IW = (N_M > 1) ? $clog2(N_M) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // State and output registers
    logic [1:0]     state_reg;
    logic [IW-1:0]  rr_last_reg;
    logic [IW-1:0]  owner_reg;
    logic [IW-1:0]  gidx_reg;
    logic           lock_q_reg;
    logic [N_M-1:0] gnt_reg;
    logic [N_M-1:0] ack_reg;
    logic [DW-1:0]  rd_data_reg;
    logic           cs_reg;
    logic           wr_reg;
    logic           rd_reg;
    logic [AW-1:0]  addr_reg;
    logic [DW-1:0]  wr_data_reg;

    // Unpacked per-master views of the packed request fields
    logic [AW-1:0]  addr_arr [N_M];
    logic [DW-1:0]  data_arr [N_M];
    logic [N_M-1:0] owner_sel;

    genvar gi;
    generate
        for (gi = 0; gi < N_M; gi++) begin : g_unpack
            assign addr_arr[gi]  = m_addr[gi*AW +: AW];
            assign data_arr[gi]  = m_wr_data[gi*DW +: DW];
            assign owner_sel[gi] = (owner_reg == IW'(gi));
        end
    endgenerate

    // Arbitration: lock only restricts eligibility while the owner still
    // asserts m_lock; a dropped m_lock releases the bus in the same cycle.
    logic           lock_hold;
    logic [N_M-1:0] eligible;
    logic           grant_valid_next;
    logic [IW-1:0]  grant_idx_next;

    always_comb begin
        int c;
        c                = 0;
        lock_hold        = lock_q_reg & m_lock[owner_reg];
        eligible         = lock_hold ? (m_req & owner_sel) : m_req;
        grant_valid_next = 1'b0;
        grant_idx_next   = '0;
        // Walk from the farthest candidate to the nearest one after rr_last,
        // so the nearest eligible master is the one left standing.
        for (int k = N_M; k >= 1; k--) begin
            c = (int'(rr_last_reg) + k) % N_M;
            if (eligible[IW'(c)]) begin
                grant_valid_next = 1'b1;
                grant_idx_next   = IW'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            rr_last_reg <= IW'(N_M - 1);
            owner_reg   <= '0;
            gidx_reg    <= '0;
            lock_q_reg  <= 1'b0;
            gnt_reg     <= '0;
            ack_reg     <= '0;
            rd_data_reg <= '0;
            cs_reg      <= 1'b0;
            wr_reg      <= 1'b0;
            rd_reg      <= 1'b0;
            addr_reg    <= '0;
            wr_data_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (lock_q_reg && !m_lock[owner_reg]) begin
                        lock_q_reg <= 1'b0;
                    end
                    if (grant_valid_next) begin
                        gidx_reg    <= grant_idx_next;
                        rr_last_reg <= grant_idx_next;
                        gnt_reg     <= N_M'(1) << grant_idx_next;
                        // Request fields are captured here only; later
                        // changes cannot disturb the transfer in flight.
                        cs_reg      <= 1'b1;
                        wr_reg      <= m_wr[grant_idx_next];
                        rd_reg      <= ~m_wr[grant_idx_next];
                        addr_reg    <= addr_arr[grant_idx_next];
                        wr_data_reg <= data_arr[grant_idx_next];
                        state_reg   <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (rd_reg) begin
                        rd_data_reg <= mmio_rd_data;
                    end
                    // Only the strobes drop; address and data hold.
                    cs_reg    <= 1'b0;
                    wr_reg    <= 1'b0;
                    rd_reg    <= 1'b0;
                    ack_reg   <= gnt_reg;
                    state_reg <= ST_ACK;
                end
                ST_ACK: begin
                    if (m_lock[gidx_reg]) begin
                        lock_q_reg <= 1'b1;
                        owner_reg  <= gidx_reg;
                    end else begin
                        lock_q_reg <= 1'b0;
                    end
                    ack_reg   <= '0;
                    gnt_reg   <= '0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_gnt        = gnt_reg;
    assign m_ack        = ack_reg;
    assign m_rd_data    = rd_data_reg;
    assign mmio_cs      = cs_reg;
    assign mmio_wr      = wr_reg;
    assign mmio_rd      = rd_reg;
    assign mmio_addr    = addr_reg;
    assign mmio_wr_data = wr_data_reg;

endmodule
